// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word requests to instruction memory, queues returned words
// with their PCs, and presents the head entry pre-split into cond/op/funct.
module instr_fetch_unit #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic        decode_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct
);
    localparam int PW = $clog2(QUEUE_DEPTH);

    // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response is stale
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_mem   [QUEUE_DEPTH];
    logic [31:0]   word_mem [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          outstanding;
    logic          space;
    logic          issue;
    logic          push;
    logic          pop;
    logic          head_valid;

    // The credit check counts the outstanding request so its response always has a slot.
    assign outstanding = (state != IDLE);
    assign space       = (count + (PW+1)'(outstanding)) < (PW+1)'(QUEUE_DEPTH);
    assign issue       = (state == IDLE) && space && !pc_src && !rst;
    assign push        = (state == WAIT) && imem_ack && !pc_src;
    assign pop         = (count != '0) && decode_ready && !pc_src;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (issue) state_next = WAIT;
            WAIT: begin
                if (imem_ack)    state_next = IDLE;
                else if (pc_src) state_next = DROP;
            end
            DROP: if (imem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (pc_src)
                fetch_pc <= {branch_target[31:2], 2'b00};
            else if (push)
                fetch_pc <= fetch_pc + 32'd4;

            // A redirect flushes the queue and overrides any same-cycle push or pop.
            if (pc_src) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PW+1)'(1);
                    2'b01:   count <= count - (PW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            word_mem[wr_ptr] <= imem_rdata;
        end
    end

    assign head_valid  = (count != '0) && !rst;
    assign imem_req    = issue;
    assign imem_addr   = rst ? 32'h0 : fetch_pc;
    assign instr_valid = head_valid;
    assign instr       = head_valid ? word_mem[rd_ptr] : 32'h0;
    assign instr_pc    = head_valid ? pc_mem[rd_ptr] : 32'h0;
    assign cond        = instr[31:28];
    assign op          = instr[27:26];
    assign funct       = instr[25:20];
endmodule
